// File: rtl/wb_io_bank_if.sv
// Wishbone classic slave bundle for wb_io_bank: strobe, cycle, write-enable, byte lanes,
// address/data and the acknowledge/read-data return path.
interface wb_io_bank_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_io_bank.sv
// Wishbone GPIO bank: output/enable registers, synchronised inputs and, with
// WB_IO_BANK_EDGE_IRQ_EN defined, rising-edge pending bits with a level interrupt.
module wb_io_bank #(
   parameter int unsigned NUM_IO   = 38,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   wb_io_bank_if.slave       wbs,
   input  logic [NUM_IO-1:0] io_in,
   output logic [NUM_IO-1:0] io_out,
   output logic [NUM_IO-1:0] io_oeb,
   output logic              irq_o
);

   logic              ack_q;
   logic [31:0]       dat_q, dat_d;
   logic [NUM_IO-1:0] out_q, out_d, oe_q, oe_d;
   logic [NUM_IO-1:0] sync1_q, sync2_q;
   logic [63:0]       out64, oe64, in64, pend64, ien64, out_m, oe_m;
   logic [31:0]       rd_word, bmask;
   logic [5:0]        word;
   logic              sel_hit, access, wr;

   logic unused_adr;
   assign unused_adr = ^wbs.wbs_adr_i[1:0];

   assign sel_hit = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
   // A select seen while ack is high is ignored, forcing one idle cycle between transfers.
   assign access  = sel_hit & ~ack_q;
   assign wr      = access & wbs.wbs_we_i;
   assign word    = wbs.wbs_adr_i[7:2];

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         bmask[8*b +: 8] = {8{wbs.wbs_sel_i[b]}};
      end
   end

   function automatic logic [63:0] merge_word(input logic [63:0] old, input logic hi,
                                              input logic [31:0] dat, input logic [31:0] msk);
      logic [63:0] r;
      r = old;
      if (hi) r[63:32] = (old[63:32] & ~msk) | (dat & msk);
      else    r[31:0]  = (old[31:0]  & ~msk) | (dat & msk);
      return r;
   endfunction

   assign out64 = 64'(out_q);
   assign oe64  = 64'(oe_q);
   assign in64  = 64'(sync2_q);

   always_comb begin
      out_m = out64;
      oe_m  = oe64;
      if (wr) begin
         case (word)
            6'd0, 6'd1: out_m = merge_word(out64, word[0], wbs.wbs_dat_i, bmask);
            6'd2, 6'd3: oe_m  = merge_word(oe64, word[0], wbs.wbs_dat_i, bmask);
            default: ;
         endcase
      end
      // Truncation drops any bits at or above NUM_IO.
      out_d = out_m[NUM_IO-1:0];
      oe_d  = oe_m[NUM_IO-1:0];
   end

   always_comb begin
      rd_word = '0;
      case (word)
         6'd0:    rd_word = out64[31:0];
         6'd1:    rd_word = out64[63:32];
         6'd2:    rd_word = oe64[31:0];
         6'd3:    rd_word = oe64[63:32];
         6'd4:    rd_word = in64[31:0];
         6'd5:    rd_word = in64[63:32];
         6'd6:    rd_word = pend64[31:0];
         6'd7:    rd_word = pend64[63:32];
         6'd8:    rd_word = ien64[31:0];
         6'd9:    rd_word = ien64[63:32];
         default: rd_word = '0;
      endcase
      dat_d = (access & ~wbs.wbs_we_i) ? rd_word : '0;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q   <= 1'b0;
         dat_q   <= '0;
         out_q   <= '0;
         oe_q    <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         ack_q   <= access;
         dat_q   <= dat_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         sync1_q <= io_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef WB_IO_BANK_EDGE_IRQ_EN
   logic [NUM_IO-1:0] dly_q, pend_q, pend_d, ien_q, ien_d, rise;
   logic [63:0]       clr64, ien_m;
   logic [1:0]        arm_q;
   logic              irq_q;

   assign pend64 = 64'(pend_q);
   assign ien64  = 64'(ien_q);

   // Edges are ignored until the synchroniser and delayed copy both hold real pad samples,
   // so a pad held high through reset never looks like a rising edge.
   assign rise = (arm_q == 2'd3) ? (sync2_q & ~dly_q) : '0;

   always_comb begin
      clr64 = '0;
      ien_m = ien64;
      if (wr) begin
         case (word)
            6'd6:       clr64[31:0]  = wbs.wbs_dat_i & bmask;
            6'd7:       clr64[63:32] = wbs.wbs_dat_i & bmask;
            6'd8, 6'd9: ien_m = merge_word(ien64, word[0], wbs.wbs_dat_i, bmask);
            default: ;
         endcase
      end
      pend_d = (pend_q & ~clr64[NUM_IO-1:0]) | rise;
      ien_d  = ien_m[NUM_IO-1:0];
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         dly_q  <= '0;
         pend_q <= '0;
         ien_q  <= '0;
         arm_q  <= 2'd0;
         irq_q  <= 1'b0;
      end else begin
         dly_q  <= sync2_q;
         pend_q <= pend_d;
         ien_q  <= ien_d;
         if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
         irq_q  <= |(pend_q & ien_q);
      end
   end

   assign irq_o = irq_q;
`else
   assign pend64 = '0;
   assign ien64  = '0;
   assign irq_o  = 1'b0;
`endif

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign io_out        = out_q;
   assign io_oeb        = ~oe_q;

endmodule

// File: tb/tb_wb_io_bank.sv
// Self-checking bench for wb_io_bank (NUM_IO = 38); expected read data goes through a queue.
module tb_wb_io_bank;
   localparam int unsigned NIO  = 38;
   localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_IO_BANK_EDGE_IRQ_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NIO-1:0] io_in = '0;
   logic [NIO-1:0] io_out, io_oeb;
   logic           irq;
   int             n_checks = 0;
   int             n_pass = 0;
   logic [31:0]    exp_q[$];
   logic [31:0]    exp, rd;
   int             lat;

   wb_io_bank_if bus_if ();

   wb_io_bank #(.NUM_IO(NIO), .BASE_ADR(BASE)) dut (
      .wb_clk_i  (clk),
      .wb_rst_n_i(rst_n),
      .wbs       (bus_if),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oeb    (io_oeb),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   // Starts at posedge+1, returns at posedge+1 one cycle after the ack (or timeout).
   task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdat, output int cyc);
      bus_if.wbs_stb_i = 1'b1; bus_if.wbs_cyc_i = 1'b1; bus_if.wbs_we_i = we;
      bus_if.wbs_adr_i = adr;  bus_if.wbs_sel_i = sel;  bus_if.wbs_dat_i = dat;
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (bus_if.wbs_ack_o !== 1'b1 && cyc < 8);
      rdat = bus_if.wbs_dat_o;
      bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0; bus_if.wbs_we_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      n_checks++; if (io_oeb !== {NIO{1'b1}}) $display("FAIL rst_oeb got %h want all ones", io_oeb); else n_pass++;
      n_checks++; if (io_out !== '0) $display("FAIL rst_out got %h want 0", io_out); else n_pass++;
      n_checks++; if ({bus_if.wbs_ack_o, irq} !== 2'b00) $display("FAIL rst_ack_irq got %b want 00", {bus_if.wbs_ack_o, irq}); else n_pass++;
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat);
      n_checks++; if (lat !== 1) $display("FAIL oe_lo_latency got %0d want 1", lat); else n_pass++;
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL oe_lo_read got %h want %h", rd, exp); else n_pass++;
   endtask

   task automatic test_out_regs();
      bus(1'b1, BASE + 32'h00, 4'b0011, 32'hA5A5_A5A5, rd, lat);
      n_checks++; if (io_out[15:0] !== 16'hA5A5 || io_out[NIO-1:16] !== '0)
         $display("FAIL out_lo_pins got %h want 00000a5a5", io_out); else n_pass++;
      exp_q.push_back(32'h0000_A5A5);
      bus(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL out_lo_read got %h want %h", rd, exp); else n_pass++;
      bus(1'b1, BASE + 32'h04, 4'hF, 32'hFFFF_FFFF, rd, lat);
      n_checks++; if (io_out[37:32] !== 6'h3F) $display("FAIL out_hi_pins got %h want 3f", io_out[37:32]); else n_pass++;
      exp_q.push_back(32'h0000_003F);
      bus(1'b0, BASE + 32'h04, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL out_hi_read got %h want %h", rd, exp); else n_pass++;
   endtask

   task automatic test_oe();
      bus(1'b1, BASE + 32'h08, 4'hF, 32'h0000_00FF, rd, lat);
      n_checks++; if (io_oeb !== {{(NIO-8){1'b1}}, 8'h00})
         $display("FAIL oe_pins got %h want 3fffffff00", io_oeb); else n_pass++;
      exp_q.push_back(32'h0000_00FF);
      bus(1'b0, BASE + 32'h08, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL oe_read got %h want %h", rd, exp); else n_pass++;
   endtask

   task automatic test_in_sync();
      io_in = 38'h2A_1234_5678;
      @(posedge clk); @(posedge clk); #1;
      exp_q.push_back(32'h1234_5678);
      bus(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL in_lo_read got %h want %h", rd, exp); else n_pass++;
      bus(1'b1, BASE + 32'h14, 4'hF, 32'h0, rd, lat);
      exp_q.push_back(32'h0000_002A);
      bus(1'b0, BASE + 32'h14, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL in_hi_read got %h want %h", rd, exp); else n_pass++;
      io_in = '0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_unmapped();
      int acks;
      acks = 0;
      bus_if.wbs_stb_i = 1'b1; bus_if.wbs_cyc_i = 1'b1; bus_if.wbs_we_i = 1'b0;
      bus_if.wbs_adr_i = 32'h3000_0100;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus_if.wbs_ack_o === 1'b1) acks++;
      end
      bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0;
      n_checks++; if (acks !== 0) $display("FAIL outside_window got %0d acks want 0", acks); else n_pass++;
      bus(1'b1, BASE + 32'h40, 4'hF, 32'hDEAD_BEEF, rd, lat);
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h40, 4'hF, 32'h0, rd, lat);
      n_checks++; if (lat !== 1) $display("FAIL unmapped_latency got %0d want 1", lat); else n_pass++;
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL unmapped_read got %h want %h", rd, exp); else n_pass++;
      exp_q.push_back(32'h0000_A5A5);
      bus(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL unmapped_no_side_effect got %h want %h", rd, exp); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acks;
      logic [31:0] idle_dat;
      acks = 0;
      idle_dat = '0;
      bus_if.wbs_stb_i = 1'b1; bus_if.wbs_cyc_i = 1'b1; bus_if.wbs_we_i = 1'b0;
      bus_if.wbs_adr_i = BASE + 32'h00; bus_if.wbs_sel_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus_if.wbs_ack_o === 1'b1) acks++;
         else idle_dat |= bus_if.wbs_dat_o;
      end
      bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (acks !== 2) $display("FAIL held_stb got %0d acks want 2", acks); else n_pass++;
      n_checks++; if (idle_dat !== 32'h0) $display("FAIL idle_dat got %h want 0", idle_dat); else n_pass++;
   endtask

   task automatic test_edge_irq();
      bus(1'b1, BASE + 32'h20, 4'hF, 32'h1, rd, lat);
      bus(1'b1, BASE + 32'h18, 4'hF, 32'hFFFF_FFFF, rd, lat);
      bus(1'b1, BASE + 32'h1C, 4'hF, 32'hFFFF_FFFF, rd, lat);
      exp_q.push_back(EDGE ? 32'h1 : 32'h0);
      bus(1'b0, BASE + 32'h20, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL ien_read got %h want %h", rd, exp); else n_pass++;
      io_in[0] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      // Sampled on the edge that captures the rise, so the old value comes back.
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h18, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL pend_pre_edge got %h want %h", rd, exp); else n_pass++;
      n_checks++; if (irq !== EDGE) $display("FAIL irq_set got %b want %b", irq, EDGE); else n_pass++;
      exp_q.push_back(EDGE ? 32'h1 : 32'h0);
      bus(1'b0, BASE + 32'h18, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL pend_set got %h want %h", rd, exp); else n_pass++;
      bus(1'b1, BASE + 32'h18, 4'hF, 32'h1, rd, lat);
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else n_pass++;
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h18, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL pend_w1c got %h want %h", rd, exp); else n_pass++;
   endtask

   task automatic test_set_wins();
      io_in[3] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      bus(1'b1, BASE + 32'h18, 4'hF, 32'h8, rd, lat);
      exp_q.push_back(EDGE ? 32'h8 : 32'h0);
      bus(1'b0, BASE + 32'h18, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL set_wins got %h want %h", rd, exp); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_masked got %b want 0", irq); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int acks;
      acks = 0;
      bus(1'b1, BASE + 32'h00, 4'hF, 32'h0000_00C3, rd, lat);
      bus_if.wbs_stb_i = 1'b1; bus_if.wbs_cyc_i = 1'b1; bus_if.wbs_we_i = 1'b0;
      bus_if.wbs_adr_i = BASE + 32'h00;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (io_out !== '0 || io_oeb !== {NIO{1'b1}})
         $display("FAIL async_reset got out %h oeb %h want 0 and all ones", io_out, io_oeb); else n_pass++;
      @(posedge clk); #1;
      bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus_if.wbs_ack_o === 1'b1) acks++;
      end
      n_checks++; if (acks !== 0) $display("FAIL aborted_ack got %0d acks want 0", acks); else n_pass++;
      // Pads 0 and 3 stayed high across reset and must not register as edges.
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h18, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL pend_after_reset got %h want %h", rd, exp); else n_pass++;
      exp_q.push_back(32'h0);
      bus(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, lat);
      exp = exp_q.pop_front();
      n_checks++; if (rd !== exp) $display("FAIL out_after_reset got %h want %h", rd, exp); else n_pass++;
   endtask

   initial begin
      bus_if.wbs_stb_i = 1'b0; bus_if.wbs_cyc_i = 1'b0; bus_if.wbs_we_i = 1'b0;
      bus_if.wbs_sel_i = 4'h0; bus_if.wbs_adr_i = '0;   bus_if.wbs_dat_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_out_regs();
      test_oe();
      test_in_sync();
      test_unmapped();
      test_back_to_back();
      test_edge_irq();
      test_set_wins();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired with %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end
endmodule
